// File: rtl/rv32i_if_id_queue_pkg.sv
// Shared definitions for the IF/ID fetch queue.
// Holds the default instruction/address bus widths, the NOP encoding driven
// to decode when the queue is empty, the default reset PC, the reset level
// and a helper that sizes queue pointers.
package rv32i_if_id_queue_pkg;

  localparam int INST_BUS_W      = 32;
  localparam int INST_ADDR_BUS_W = 32;

  typedef logic [INST_BUS_W-1:0]      inst_bus_t;
  typedef logic [INST_ADDR_BUS_W-1:0] inst_addr_bus_t;

  // addi x0, x0, 0
  localparam inst_bus_t      NOP_ENC      = 32'h0000_0013;
  localparam inst_addr_bus_t RESET_PC_DEF = 32'h0000_0000;

  // Level of rst that holds the block in reset
  localparam logic RST_ASSERTED = 1'b0;

  // Pointer width for a DEPTH-entry array; a single entry still gets one bit
  function automatic int ptr_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/rv32i_if_id_queue_if.sv
// Fetch-to-decode handshake bundle for the IF/ID queue.
//   if_valid/if_ready/if_inst/if_pc : fetch side, valid/ready
//   id_stall/id_valid/id_inst/id_pc : decode side, valid/stall
// master: the pipeline around the queue (fetch + decode)
// slave : the queue itself
interface rv32i_if_id_queue_if #(
  parameter int XLEN = 32,
  parameter int ILEN = 32
);

  logic            if_valid;
  logic            if_ready;
  logic [ILEN-1:0] if_inst;
  logic [XLEN-1:0] if_pc;

  logic            id_stall;
  logic            id_valid;
  logic [ILEN-1:0] id_inst;
  logic [XLEN-1:0] id_pc;

  modport master (
    output if_valid, if_inst, if_pc, id_stall,
    input  if_ready, id_valid, id_inst, id_pc
  );

  modport slave (
    input  if_valid, if_inst, if_pc, id_stall,
    output if_ready, id_valid, id_inst, id_pc
  );

endinterface

// File: rtl/rv32i_ifq_storage.sv
// Entry storage for the IF/ID queue: DEPTH x WIDTH register array.
//   clk   : clock, rising edge
//   we    : write enable
//   waddr : write index
//   wdata : entry to store
//   raddr : read index
//   rdata : entry at raddr (combinational read)
// Data carries no reset: the top never presents an entry it has not written.
module rv32i_ifq_storage
  import rv32i_if_id_queue_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int WIDTH = 64,
  parameter int AW    = ptr_w(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/rv32i_if_id_queue.sv
// IF/ID pipeline boundary built as a DEPTH-entry fetch queue.
//   clk       : clock, rising edge
//   rst       : asynchronous, active-low reset
//   bus       : fetch valid/ready and decode valid/stall handshake (slave)
//   flush     : per-source squash requests, OR-reduced
//   q_count   : current occupancy
//   flush_cnt : saturating count of cycles with any flush asserted
// Outputs to decode come only from registers and the storage read port, so
// there is no combinational path from if_* to id_*, and if_ready depends on
// the occupancy register alone.
module rv32i_if_id_queue
  import rv32i_if_id_queue_pkg::*;
#(
  parameter int              XLEN      = INST_ADDR_BUS_W,
  parameter int              ILEN      = INST_BUS_W,
  parameter int              DEPTH     = 2,
  parameter int              NUM_FLUSH = 2,
  parameter logic [ILEN-1:0] NOP_INST  = NOP_ENC,
  parameter logic [XLEN-1:0] RESET_PC  = RESET_PC_DEF,
  parameter int              CNT_W     = 16
) (
  input  logic                         clk,
  input  logic                         rst,
  rv32i_if_id_queue_if.slave           bus,
  input  logic [NUM_FLUSH-1:0]         flush,
  output logic [$clog2(DEPTH+1)-1:0]   q_count,
  output logic [CNT_W-1:0]             flush_cnt
);

  localparam int             CW       = $clog2(DEPTH + 1);
  localparam int             AW       = ptr_w(DEPTH);
  localparam int             EW       = XLEN + ILEN;
  localparam logic [CW-1:0]  DEPTH_C  = CW'(DEPTH);
  localparam logic [AW-1:0]  LAST_PTR = AW'(DEPTH - 1);

  logic [CW-1:0]    count_q;
  logic [AW-1:0]    rd_ptr_q;
  logic [AW-1:0]    wr_ptr_q;
  logic [XLEN-1:0]  held_pc_q;
  logic [CNT_W-1:0] flush_cnt_q;

  logic             any_flush;
  logic             ready;
  logic             valid;
  logic             push;
  logic             pop;
  logic [EW-1:0]    head;
  logic [XLEN-1:0]  head_pc;
  logic [ILEN-1:0]  head_inst;

  // Explicit wrap so non-power-of-two depths work
  function automatic logic [AW-1:0] ptr_next(input logic [AW-1:0] p);
    return (p == LAST_PTR) ? '0 : p + AW'(1);
  endfunction

  assign any_flush = |flush;
  assign ready     = (count_q < DEPTH_C);
  assign valid     = (count_q != '0);

  // Flush dominates: nothing enters or leaves on a squash cycle
  assign push = bus.if_valid & ready & ~any_flush;
  assign pop  = valid & ~bus.id_stall & ~any_flush;

  rv32i_ifq_storage #(
    .DEPTH (DEPTH),
    .WIDTH (EW),
    .AW    (AW)
  ) u_storage (
    .clk   (clk),
    .we    (push),
    .waddr (wr_ptr_q),
    .wdata ({bus.if_pc, bus.if_inst}),
    .raddr (rd_ptr_q),
    .rdata (head)
  );

  assign head_pc   = head[EW-1:ILEN];
  assign head_inst = head[ILEN-1:0];

  always_ff @(posedge clk or negedge rst) begin
    if (rst == RST_ASSERTED) begin
      count_q  <= '0;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
    end else if (any_flush) begin
      count_q  <= '0;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
    end else begin
      if (push) begin
        wr_ptr_q <= ptr_next(wr_ptr_q);
      end
      if (pop) begin
        rd_ptr_q <= ptr_next(rd_ptr_q);
      end
      if (push && !pop) begin
        count_q <= count_q + CW'(1);
      end else if (pop && !push) begin
        count_q <= count_q - CW'(1);
      end
    end
  end

  // Remembers the PC of the last instruction that left the queue, either by
  // being consumed or by being the oldest one squashed, so an empty queue
  // still shows decode a meaningful PC.
  always_ff @(posedge clk or negedge rst) begin
    if (rst == RST_ASSERTED) begin
      held_pc_q <= RESET_PC;
    end else if ((any_flush && valid) || pop) begin
      held_pc_q <= head_pc;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (rst == RST_ASSERTED) begin
      flush_cnt_q <= '0;
    end else if (any_flush && (flush_cnt_q != '1)) begin
      flush_cnt_q <= flush_cnt_q + CNT_W'(1);
    end
  end

  assign bus.if_ready = ready;
  assign bus.id_valid = valid;
  assign bus.id_inst  = valid ? head_inst : NOP_INST;
  assign bus.id_pc    = valid ? head_pc : held_pc_q;
  assign q_count      = count_q;
  assign flush_cnt    = flush_cnt_q;

endmodule

// File: tb/tb_rv32i_if_id_queue.sv
module tb_rv32i_if_id_queue;

  localparam logic [31:0] NOP   = 32'h0000_0013;
  localparam logic [31:0] RPC2  = 32'h0000_0000;
  localparam logic [31:0] RPC3  = 32'h0000_0200;

  logic        clk;
  logic        rst;
  logic        iv;
  logic        ist;
  logic [31:0] ipc;
  logic [31:0] iinst;
  logic [1:0]  fl;

  logic [1:0]  qc2;
  logic [3:0]  fcnt2;
  logic [1:0]  qc3;
  logic [15:0] fcnt3;

  int n_assert = 0;
  int n_fail   = 0;

  // Reference model: one queue of {pc, inst} per DUT
  logic [63:0] q2[$];
  logic [63:0] q3[$];
  logic [31:0] held2, held3;
  int          fc2, fc3;

  rv32i_if_id_queue_if #(.XLEN(32), .ILEN(32)) bus2 ();
  rv32i_if_id_queue_if #(.XLEN(32), .ILEN(32)) bus3 ();

  assign bus2.if_valid = iv;
  assign bus2.if_inst  = iinst;
  assign bus2.if_pc    = ipc;
  assign bus2.id_stall = ist;
  assign bus3.if_valid = iv;
  assign bus3.if_inst  = iinst;
  assign bus3.if_pc    = ipc;
  assign bus3.id_stall = ist;

  rv32i_if_id_queue #(
    .XLEN(32), .ILEN(32), .DEPTH(2), .NUM_FLUSH(2),
    .NOP_INST(NOP), .RESET_PC(RPC2), .CNT_W(4)
  ) u_dut2 (
    .clk(clk), .rst(rst), .bus(bus2), .flush(fl),
    .q_count(qc2), .flush_cnt(fcnt2)
  );

  rv32i_if_id_queue #(
    .XLEN(32), .ILEN(32), .DEPTH(3), .NUM_FLUSH(2),
    .NOP_INST(NOP), .RESET_PC(RPC3), .CNT_W(16)
  ) u_dut3 (
    .clk(clk), .rst(rst), .bus(bus3), .flush(fl),
    .q_count(qc3), .flush_cnt(fcnt3)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    q2.delete();
    q3.delete();
    held2 = RPC2;
    held3 = RPC3;
    fc2   = 0;
    fc3   = 0;
  endtask

  // Compare every visible output of both DUTs with the model's current state
  task automatic check_dut(input string ph);
    for (int k = 0; k < 2; k++) begin
      logic [63:0] q[$];
      int          d;
      logic [31:0] held;
      int          fc;
      logic [31:0] o_v, o_i, o_p, o_r, o_c, o_f;
      logic [31:0] e_i, e_p;
      if (k == 0) begin
        q = q2; d = 2; held = held2; fc = fc2;
        o_v = 32'(bus2.id_valid); o_i = bus2.id_inst; o_p = bus2.id_pc;
        o_r = 32'(bus2.if_ready); o_c = 32'(qc2); o_f = 32'(fcnt2);
      end else begin
        q = q3; d = 3; held = held3; fc = fc3;
        o_v = 32'(bus3.id_valid); o_i = bus3.id_inst; o_p = bus3.id_pc;
        o_r = 32'(bus3.if_ready); o_c = 32'(qc3); o_f = 32'(fcnt3);
      end
      e_i = (q.size() != 0) ? q[0][31:0]  : NOP;
      e_p = (q.size() != 0) ? q[0][63:32] : held;
      chk($sformatf("%s d%0d id_valid", ph, d), o_v, (q.size() != 0) ? 32'd1 : 32'd0);
      chk($sformatf("%s d%0d id_inst", ph, d), o_i, e_i);
      chk($sformatf("%s d%0d id_pc", ph, d), o_p, e_p);
      chk($sformatf("%s d%0d if_ready", ph, d), o_r, (q.size() < d) ? 32'd1 : 32'd0);
      chk($sformatf("%s d%0d q_count", ph, d), o_c, 32'(q.size()));
      chk($sformatf("%s d%0d flush_cnt", ph, d), o_f, 32'(fc));
    end
  endtask

  // Advance one model by one clock edge using the currently driven inputs
  task automatic model_step(input int k);
    logic [63:0] q[$];
    int          d;
    logic [31:0] held;
    int          fc;
    int          fmax;
    bit          room;
    if (k == 0) begin q = q2; d = 2; held = held2; fc = fc2; fmax = 15; end
    else        begin q = q3; d = 3; held = held3; fc = fc3; fmax = 65535; end
    if (fl != 2'b00) begin
      if (q.size() != 0) held = q[0][63:32];
      q.delete();
      if (fc < fmax) fc++;
    end else begin
      room = (q.size() < d);
      if (q.size() != 0 && !ist) begin
        held = q[0][63:32];
        void'(q.pop_front());
      end
      if (iv && room) q.push_back({ipc, iinst});
    end
    if (k == 0) begin q2 = q; held2 = held; fc2 = fc; end
    else        begin q3 = q; held3 = held; fc3 = fc; end
  endtask

  // One clock: drive, check on the falling edge, update model, land after rise
  task automatic cycle(input logic v, input logic [31:0] pc, input logic [31:0] inst,
                       input logic s, input logic [1:0] f, input string ph);
    iv = v; ipc = pc; iinst = inst; ist = s; fl = f;
    @(negedge clk);
    check_dut(ph);
    model_step(0);
    model_step(1);
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n, input string ph);
    for (int i = 0; i < n; i++) cycle(1'b0, 32'h0, 32'h0, 1'b0, 2'b00, ph);
  endtask

  initial begin
    rst = 1'b0; iv = 1'b0; ist = 1'b0; ipc = '0; iinst = '0; fl = '0;
    model_reset();

    // Reset state
    @(negedge clk);
    chk("rst d2 id_valid", 32'(bus2.id_valid), 32'd0);
    chk("rst d2 id_inst", bus2.id_inst, NOP);
    chk("rst d2 id_pc", bus2.id_pc, RPC2);
    chk("rst d3 id_pc", bus3.id_pc, RPC3);
    chk("rst d2 q_count", 32'(qc2), 32'd0);
    chk("rst d2 flush_cnt", 32'(fcnt2), 32'd0);
    @(posedge clk); #2 rst = 1'b1;

    // Streaming with no stall: one cycle behind, occupancy stays at one
    cycle(1'b1, 32'h0, 32'h0010_0093, 1'b0, 2'b00, "stream");
    chk("stream pc0", bus2.id_pc, 32'h0);
    cycle(1'b1, 32'h4, 32'h0020_0113, 1'b0, 2'b00, "stream");
    chk("stream pc4", bus2.id_pc, 32'h4);
    chk("stream q_count", 32'(qc2), 32'd1);
    cycle(1'b1, 32'h8, 32'h0030_0193, 1'b0, 2'b00, "stream");
    chk("stream pc8", bus2.id_pc, 32'h8);
    chk("stream inst8", bus2.id_inst, 32'h0030_0193);
    idle(1, "stream");
    chk("stream empty inst", bus2.id_inst, NOP);
    chk("stream held pc", bus2.id_pc, 32'h8);
    idle(1, "stream");

    // Stall while fetch keeps filling
    cycle(1'b1, 32'h10, 32'hA000_0010, 1'b1, 2'b00, "stall");
    chk("stall hold pc", bus2.id_pc, 32'h10);
    cycle(1'b1, 32'h14, 32'hA000_0014, 1'b1, 2'b00, "stall");
    chk("stall hold pc", bus2.id_pc, 32'h10);
    cycle(1'b1, 32'h18, 32'hA000_0018, 1'b1, 2'b00, "stall");
    chk("stall hold pc", bus2.id_pc, 32'h10);
    cycle(1'b1, 32'h18, 32'hA000_0018, 1'b1, 2'b00, "stall");
    chk("stall full q_count", 32'(qc2), 32'd2);
    chk("stall full if_ready", 32'(bus2.if_ready), 32'd0);
    chk("stall hold pc", bus2.id_pc, 32'h10);
    cycle(1'b1, 32'h18, 32'hA000_0018, 1'b0, 2'b00, "stall");
    chk("stall release pc", bus2.id_pc, 32'h14);
    chk("stall release q_count", 32'(qc2), 32'd1);
    cycle(1'b1, 32'h18, 32'hA000_0018, 1'b0, 2'b00, "stall");
    chk("stall 18 accepted", bus2.id_pc, 32'h18);
    idle(5, "stall");

    // Flush with a concurrent fetch
    cycle(1'b1, 32'h20, 32'hB000_0020, 1'b1, 2'b00, "flush");
    cycle(1'b1, 32'h24, 32'hB000_0024, 1'b1, 2'b00, "flush");
    cycle(1'b1, 32'h28, 32'hB000_0028, 1'b0, 2'b10, "flush");
    chk("flush id_valid", 32'(bus2.id_valid), 32'd0);
    chk("flush id_inst", bus2.id_inst, NOP);
    chk("flush id_pc", bus2.id_pc, 32'h20);
    chk("flush q_count", 32'(qc2), 32'd0);
    chk("flush flush_cnt", 32'(fcnt2), 32'd1);
    idle(2, "flush");

    // Counter saturation
    cycle(1'b1, 32'h30, 32'h0, 1'b0, 2'b11, "sat");
    for (int i = 0; i < 20; i++) cycle(1'b1, 32'h30, 32'h0, 1'b0, 2'b01, "sat");
    chk("sat d2 flush_cnt", 32'(fcnt2), 32'd15);
    chk("sat d3 flush_cnt", 32'(fcnt3), 32'd22);
    cycle(1'b0, 32'h0, 32'h0, 1'b0, 2'b01, "sat");
    chk("sat d2 hold", 32'(fcnt2), 32'd15);
    idle(2, "sat");

    // Full DEPTH=3 queue with pop and fetch together, then wrap
    cycle(1'b1, 32'h40, 32'hC000_0040, 1'b1, 2'b00, "wrap");
    cycle(1'b1, 32'h44, 32'hC000_0044, 1'b1, 2'b00, "wrap");
    cycle(1'b1, 32'h48, 32'hC000_0048, 1'b1, 2'b00, "wrap");
    chk("wrap d3 full", 32'(qc3), 32'd3);
    chk("wrap d3 if_ready", 32'(bus3.if_ready), 32'd0);
    cycle(1'b1, 32'h4C, 32'hC000_004C, 1'b0, 2'b00, "wrap");
    chk("wrap d3 no push", 32'(qc3), 32'd2);
    chk("wrap d3 pc44", bus3.id_pc, 32'h44);
    cycle(1'b1, 32'h4C, 32'hC000_004C, 1'b0, 2'b00, "wrap");
    chk("wrap d3 pc48", bus3.id_pc, 32'h48);
    cycle(1'b1, 32'h50, 32'hC000_0050, 1'b0, 2'b00, "wrap");
    cycle(1'b1, 32'h54, 32'hC000_0054, 1'b0, 2'b00, "wrap");
    cycle(1'b1, 32'h58, 32'hC000_0058, 1'b0, 2'b00, "wrap");
    idle(4, "wrap");

    // Asynchronous reset between edges
    cycle(1'b1, 32'h60, 32'hD000_0060, 1'b1, 2'b00, "arst");
    cycle(1'b1, 32'h64, 32'hD000_0064, 1'b1, 2'b00, "arst");
    iv = 1'b0;
    #2 rst = 1'b0;
    #1;
    chk("arst d2 id_valid", 32'(bus2.id_valid), 32'd0);
    chk("arst d2 id_inst", bus2.id_inst, NOP);
    chk("arst d2 id_pc", bus2.id_pc, RPC2);
    chk("arst d3 id_pc", bus3.id_pc, RPC3);
    chk("arst d3 q_count", 32'(qc3), 32'd0);
    chk("arst d3 flush_cnt", 32'(fcnt3), 32'd0);
    chk("arst d2 if_ready", 32'(bus2.if_ready), 32'd1);
    model_reset();
    @(posedge clk); #2 rst = 1'b1;
    cycle(1'b1, 32'h100, 32'hE000_0100, 1'b0, 2'b00, "arst");
    chk("arst first pc", bus2.id_pc, 32'h100);
    cycle(1'b1, 32'h104, 32'hE000_0104, 1'b0, 2'b00, "arst");
    chk("arst second pc", bus3.id_pc, 32'h104);
    idle(2, "arst");

    // Randomised traffic
    for (int i = 0; i < 400; i++) begin
      logic        rv, rs;
      logic [1:0]  rf;
      logic [31:0] rpc;
      rv  = 1'($urandom_range(0, 3) != 0);
      rs  = 1'($urandom_range(0, 2) == 0);
      rf  = ($urandom_range(0, 15) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
      rpc = {$urandom_range(0, 32'h3FFF_FFFF), 2'b00};
      cycle(rv, rpc, $urandom, rs, rf, "rand");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/rv32i_if_id_queue.md
Name: rv32i_if_id_queue

Overview:
Parametrised IF/ID pipeline boundary that replaces the single-entry IF/ID register with a DEPTH-entry fetch queue.
- Upstream: valid/ready handshake with fetch. Downstream: valid/stall handshake with decode.
- NUM_FLUSH independent flush sources (ID redirect, EX redirect, trap, ...) squash all queued instructions.
- Presents NOP/invalid to ID whenever empty. Keeps a saturating flush counter for performance monitoring.

Parameters:
- XLEN, 32, PC width
- ILEN, 32, instruction width
- DEPTH, 2, queue entries (>=1, need not be power of two)
- NUM_FLUSH, 2, number of flush request inputs
- NOP_INST, 32'h00000013, instruction driven to ID when queue empty (addi x0,x0,0)
- RESET_PC, 32'h00000000, id_pc value after reset
- CNT_W, 16, flush counter width

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  one clock; reset is asynchronous and active-low
- if_valid  in  1  fetch presents an instruction
- if_ready  out  1  queue can accept this cycle
- if_inst  in  ILEN  fetched instruction
- if_pc  in  XLEN  PC of fetched instruction
- flush  in  NUM_FLUSH  per-source squash request, OR-reduced
- id_stall  in  1  decode cannot consume the head entry
- id_valid  out  1  head entry valid
- id_inst  out  ILEN  head instruction, or NOP_INST when empty
- id_pc  out  XLEN  head PC, or held PC when empty
- q_count  out  $clog2(DEPTH+1)  current occupancy
- flush_cnt  out  CNT_W  saturating count of flush cycles

Behaviour:
Reset (rst=0, asynchronous, immediate):
- count=0, rd/wr pointers=0, id_valid=0, id_inst=NOP_INST, id_pc=RESET_PC, held_pc=RESET_PC, flush_cnt=0.
- A reset asserted mid-operation discards all entries.
- if_ready=1 in the first cycle after deassertion.

Handshake:
- if_ready = (count < DEPTH). This is a register-derived signal with no combinational path from id_stall or flush.
- push = if_valid & if_ready & ~any_flush.
- pop = id_valid & ~id_stall & ~any_flush.
- any_flush = |flush.

Latency:
- An entry pushed in cycle N is visible on id_* in cycle N+1 at the earliest.
- No bypass from if_* to id_*.

Outputs:
- id_valid = (count != 0).
- id_inst/id_pc read from the head entry when valid.
- When empty: id_inst = NOP_INST and id_pc = held_pc.
- held_pc updates to the head PC on every pop and on flush when non-empty (the PC of the first squashed entry).

Queue operation:
- Push writes at wr_ptr.
- Pop advances rd_ptr.
- Pointers wrap from DEPTH-1 to 0 explicitly.
- Push and pop in the same cycle: count unchanged, both pointers advance.
- When full, if_ready=0, so a push is impossible even if a pop occurs that cycle.

Flush:
- Dominates push, pop and stall.
- Next cycle: count=0, rd_ptr=wr_ptr=0, id_valid=0, id_inst=NOP_INST. Incoming if_valid in the flush cycle is dropped.
- Multiple flush bits in one cycle count as one event.
- flush_cnt increments by 1 per cycle with any_flush=1 and saturates at all-ones.

Stall:
- id_stall=1 holds id_* stable while fetch may keep filling until full.
- id_stall while empty has no effect.

DEPTH=1 degenerates to a single-entry register with handshake (throughput 1 per 2 cycles under continuous flow).

Decomposition:
- Shared package / DEFINES: NOP encoding, RESET_PC default, InstBus/InstAddrBus widths, active-low reset level constant.
- Sub-module rv32i_ifq_storage: DEPTH x (ILEN+XLEN) register array with write port (we, waddr, wdata) and asynchronous read port (raddr). Pointer, count and flush logic stay in the top.

Test Plan:
- Reset, then if_valid=1 streaming pc 0x0,0x4,0x8 with inst 0x00100093,0x00200113,0x00300193, id_stall=0 -> id_valid=1 from cycle 1; id_pc sequence 0x0,0x4,0x8 one cycle behind; q_count stays <=1.
- DEPTH=2, id_stall=1 for 4 cycles while fetch streams 0x10,0x14,0x18 -> q_count reaches 2; if_ready=0; 0x18 not accepted until stall drops; id_pc held at 0x10 throughout the stall.
- Queue holding 0x20,0x24 and flush=2'b10 with if_valid=1 (pc 0x28) in the same cycle -> next cycle id_valid=0, id_inst=0x00000013, id_pc=0x20, q_count=0, flush_cnt=1; 0x28 never appears.
- flush=2'b11 for one cycle, then 2'b01 for CNT_W-saturation test (CNT_W=4, 20 flush cycles) -> flush_cnt=15 and holds.
- Full queue (DEPTH=3) with simultaneous pop and if_valid -> no push that cycle; q_count 3->2; pointer wrap verified by PCs 0x40..0x58 exiting in order.
- rst pulled low asynchronously mid-stream between clock edges -> outputs go to reset values immediately; after release the first pushed pc 0x100 appears in order.
